// File: rtl/stage_sequencer_pkg.sv
// Shared stage, stage-index and fault-cause definitions for the stage sequencer and its helpers.
package stage_sequencer_pkg;

    localparam int NUM_STAGES      = 5;
    localparam int STAGE_FETCH     = 0;
    localparam int STAGE_DECODE    = 1;
    localparam int STAGE_EXECUTE   = 2;
    localparam int STAGE_MEMORY    = 3;
    localparam int STAGE_WRITEBACK = 4;

    localparam logic [NUM_STAGES-1:0] DEFAULT_STAGE_ACTIVE = 5'b00001;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
    localparam logic [1:0] FAULT_FETCH_TO = 2'b10;
    localparam logic [1:0] FAULT_MEM_TO   = 2'b11;

    // One-hot stage encoding; the all-zero code doubles as the parked FAULT state.
    typedef enum logic [NUM_STAGES-1:0] {
        ST_FAULT     = '0,
        ST_FETCH     = NUM_STAGES'(1 << STAGE_FETCH),
        ST_DECODE    = NUM_STAGES'(1 << STAGE_DECODE),
        ST_EXECUTE   = NUM_STAGES'(1 << STAGE_EXECUTE),
        ST_MEMORY    = NUM_STAGES'(1 << STAGE_MEMORY),
        ST_WRITEBACK = NUM_STAGES'(1 << STAGE_WRITEBACK)
    } stage_t;

endpackage

// File: rtl/stage_sequencer_wait_timer.sv
// Bus wait counter: counts consecutive unacked request cycles and flags the cycle
// in which the allowed wait budget is used up without an ack.
module stage_wait_timer
    import stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clk,
    input  logic clear,
    input  logic restart,
    input  logic count_en,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (clear || restart) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

    // count holds the number of earlier unacked cycles, so this is the last allowed one.
    assign expired = count_en && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Control FSM for the multi-cycle core: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// runs the bus handshakes with timeouts, parks on debug halt, latches faults and counts retirements.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   clear,
    output logic [NUM_STAGES-1:0]  stage_out,
    output logic                   fetch_req,
    input  logic                   fetch_ack,
    input  logic                   decode_mem_op,
    input  logic                   decode_fault,
    input  logic                   exec_busy,
    output logic                   mem_req,
    input  logic                   mem_ack,
    input  logic                   halt,
    output logic                   halted,
    output logic                   fault,
    output logic [1:0]             fault_cause,
    output logic                   retire,
    output logic [COUNT_WIDTH-1:0] retire_count
);

    stage_t     dff_stages;
    stage_t     next_stage;
    logic [1:0] next_cause;
    logic       mem_op;
    logic       fetch_active;
    logic       mem_active;
    logic       wait_en;
    logic       timer_restart;
    logic       timer_expired;

    // Request qualification ignores clear so the FSM sees the true handshake; outputs are masked.
    always_comb begin
        fetch_active = (dff_stages == ST_FETCH) && !halted && !fault;
        mem_active   = (dff_stages == ST_MEMORY) && !fault;
        wait_en      = (fetch_active && !fetch_ack) || (mem_active && !mem_ack);
    end

    assign fetch_req = fetch_active && !clear;
    assign mem_req   = mem_active && !clear;
    assign retire    = (dff_stages == ST_WRITEBACK) && !clear;
    assign stage_out = dff_stages;

    always_comb begin
        next_stage = dff_stages;
        next_cause = FAULT_NONE;
        unique case (dff_stages)
            ST_FETCH: begin
                if (fetch_active && fetch_ack) begin
                    next_stage = ST_DECODE;
                end else if (timer_expired) begin
                    next_stage = ST_FAULT;
                    next_cause = FAULT_FETCH_TO;
                end
            end
            ST_DECODE: begin
                if (decode_fault) begin
                    next_stage = ST_FAULT;
                    next_cause = FAULT_ILLEGAL;
                end else begin
                    next_stage = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (!exec_busy) begin
                    next_stage = mem_op ? ST_MEMORY : ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (mem_active && mem_ack) begin
                    next_stage = ST_WRITEBACK;
                end else if (timer_expired) begin
                    next_stage = ST_FAULT;
                    next_cause = FAULT_MEM_TO;
                end
            end
            ST_WRITEBACK: next_stage = ST_FETCH;
            default:      next_stage = ST_FAULT;
        endcase
    end

    // Any break in an unacked request run (stage change or request drop) restarts the wait count.
    assign timer_restart = (next_stage != dff_stages) || !wait_en;

    stage_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_wait_timer (
        .clk      (clk),
        .clear    (clear),
        .restart  (timer_restart),
        .count_en (wait_en),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            dff_stages   <= stage_t'(DEFAULT_STAGE_ACTIVE);
            fault        <= 1'b0;
            fault_cause  <= FAULT_NONE;
            halted       <= 1'b0;
            mem_op       <= 1'b0;
            retire_count <= '0;
        end else begin
            dff_stages <= next_stage;
            if ((next_stage == ST_FAULT) && !fault) begin
                fault       <= 1'b1;
                fault_cause <= next_cause;
            end
            if (dff_stages == ST_DECODE) begin
                mem_op <= decode_mem_op;
            end
            // A halt seen during WRITEBACK parks the core on arrival in FETCH, so no fetch leaks out.
            if (halted) begin
                halted <= halt;
            end else if (((dff_stages == ST_FETCH) && !fetch_ack) || (dff_stages == ST_WRITEBACK)) begin
                halted <= halt;
            end
            if (dff_stages == ST_WRITEBACK) begin
                retire_count <= retire_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_stage_sequencer;

    logic        clk;
    logic        clear;
    logic [4:0]  stage_out;
    logic        fetch_req;
    logic        fetch_ack;
    logic        decode_mem_op;
    logic        decode_fault;
    logic        exec_busy;
    logic        mem_req;
    logic        mem_ack;
    logic        halt;
    logic        halted;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        retire;
    logic [31:0] retire_count;

    typedef struct {
        string       tag;
        logic [4:0]  stage;
        logic [4:0]  flags;
        logic [1:0]  cause;
        logic [31:0] count;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_entry;
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    stage_sequencer #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (8),
        .COUNT_WIDTH    (32)
    ) dut (
        .clk           (clk),
        .clear         (clear),
        .stage_out     (stage_out),
        .fetch_req     (fetch_req),
        .fetch_ack     (fetch_ack),
        .decode_mem_op (decode_mem_op),
        .decode_fault  (decode_fault),
        .exec_busy     (exec_busy),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .halt          (halt),
        .halted        (halted),
        .fault         (fault),
        .fault_cause   (fault_cause),
        .retire        (retire),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_vec = {clear, fetch_ack, decode_mem_op, decode_fault, exec_busy, mem_ack, halt}
    // e_flags = {fetch_req, mem_req, retire, halted, fault}
    task automatic applyStimulus(input string name, input logic [6:0] in_vec,
                                 input logic [4:0] e_stage, input logic [4:0] e_flags,
                                 input logic [1:0] e_cause, input logic [31:0] e_count);
        exp_t e;
        @(posedge clk);
        #1;
        {clear, fetch_ack, decode_mem_op, decode_fault, exec_busy, mem_ack, halt} = in_vec;
        step++;
        e.tag   = $sformatf("%s#%0d", name, step);
        e.stage = e_stage;
        e.flags = e_flags;
        e.cause = e_cause;
        e.count = e_count;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [4:0] got_flags;
        got_flags = {fetch_req, mem_req, retire, halted, fault};
        total++;
        if (stage_out !== e.stage || got_flags !== e.flags ||
            fault_cause !== e.cause || retire_count !== e.count) begin
            bad++;
            $display("[TB] FAIL %s: got stage=%b flags=%b cause=%b count=%0d, want stage=%b flags=%b cause=%b count=%0d",
                     e.tag, stage_out, got_flags, fault_cause, retire_count,
                     e.stage, e.flags, e.cause, e.count);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_entry = exp_q.pop_front();
            checkOutput(mon_entry);
        end
    end

    initial begin
        {clear, fetch_ack, decode_mem_op, decode_fault, exec_busy, mem_ack, halt} = 7'b1000000;
        repeat (2) @(posedge clk);

        applyStimulus("reset",     7'b1000000, 5'b00001, 5'b00000, 2'b00, 0);
        // ALU op with fetch_ack in the first request cycle
        applyStimulus("alu",       7'b0100000, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("alu",       7'b0000000, 5'b00010, 5'b00000, 2'b00, 0);
        applyStimulus("alu",       7'b0000000, 5'b00100, 5'b00000, 2'b00, 0);
        applyStimulus("alu",       7'b0000000, 5'b10000, 5'b00100, 2'b00, 0);
        // Load, one idle fetch cycle then mem_ack on third mem_req cycle
        applyStimulus("load",      7'b0000000, 5'b00001, 5'b10000, 2'b00, 1);
        applyStimulus("load",      7'b0100000, 5'b00001, 5'b10000, 2'b00, 1);
        applyStimulus("load",      7'b0010000, 5'b00010, 5'b00000, 2'b00, 1);
        applyStimulus("load",      7'b0000000, 5'b00100, 5'b00000, 2'b00, 1);
        applyStimulus("load",      7'b0000000, 5'b01000, 5'b01000, 2'b00, 1);
        applyStimulus("load",      7'b0000000, 5'b01000, 5'b01000, 2'b00, 1);
        applyStimulus("load",      7'b0000010, 5'b01000, 5'b01000, 2'b00, 1);
        applyStimulus("load",      7'b0000000, 5'b10000, 5'b00100, 2'b00, 1);
        // mem_ack in the last allowed (4th) request cycle
        applyStimulus("memlast",   7'b0100000, 5'b00001, 5'b10000, 2'b00, 2);
        applyStimulus("memlast",   7'b0010000, 5'b00010, 5'b00000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000000, 5'b00100, 5'b00000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000000, 5'b01000, 5'b01000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000000, 5'b01000, 5'b01000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000000, 5'b01000, 5'b01000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000010, 5'b01000, 5'b01000, 2'b00, 2);
        applyStimulus("memlast",   7'b0000000, 5'b10000, 5'b00100, 2'b00, 2);
        // mem_ack withheld: memory timeout, late acks and halt ignored
        applyStimulus("memto",     7'b0100000, 5'b00001, 5'b10000, 2'b00, 3);
        applyStimulus("memto",     7'b0010000, 5'b00010, 5'b00000, 2'b00, 3);
        applyStimulus("memto",     7'b0000000, 5'b00100, 5'b00000, 2'b00, 3);
        for (int i = 0; i < 4; i++)
            applyStimulus("memto", 7'b0000000, 5'b01000, 5'b01000, 2'b00, 3);
        applyStimulus("memto",     7'b0000010, 5'b00000, 5'b00001, 2'b11, 3);
        applyStimulus("memto",     7'b0100001, 5'b00000, 5'b00001, 2'b11, 3);
        applyStimulus("memto",     7'b1000000, 5'b00000, 5'b00001, 2'b11, 3);
        // Fetch timeout after four unacked request cycles
        for (int i = 0; i < 4; i++)
            applyStimulus("fetchto", 7'b0000000, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("fetchto",   7'b0100000, 5'b00000, 5'b00001, 2'b10, 0);
        applyStimulus("fetchto",   7'b1000000, 5'b00000, 5'b00001, 2'b10, 0);
        // fetch_ack in the last allowed request cycle
        for (int i = 0; i < 3; i++)
            applyStimulus("fetchlast", 7'b0000000, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("fetchlast", 7'b0100000, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("fetchlast", 7'b0000000, 5'b00010, 5'b00000, 2'b00, 0);
        // Halt raised during a two-cycle busy EXECUTE
        applyStimulus("halt",      7'b0000101, 5'b00100, 5'b00000, 2'b00, 0);
        applyStimulus("halt",      7'b0000101, 5'b00100, 5'b00000, 2'b00, 0);
        applyStimulus("halt",      7'b0000001, 5'b00100, 5'b00000, 2'b00, 0);
        applyStimulus("halt",      7'b0000001, 5'b10000, 5'b00100, 2'b00, 0);
        applyStimulus("halt",      7'b0100001, 5'b00001, 5'b00010, 2'b00, 1);
        applyStimulus("halt",      7'b0000000, 5'b00001, 5'b00010, 2'b00, 1);
        applyStimulus("halt",      7'b0100000, 5'b00001, 5'b10000, 2'b00, 1);
        // Illegal instruction
        applyStimulus("illegal",   7'b0001000, 5'b00010, 5'b00000, 2'b00, 1);
        applyStimulus("illegal",   7'b0000000, 5'b00000, 5'b00001, 2'b01, 1);
        applyStimulus("illegal",   7'b1000000, 5'b00000, 5'b00001, 2'b01, 1);
        // clear in the middle of MEMORY
        applyStimulus("clrmem",    7'b0100000, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("clrmem",    7'b0010000, 5'b00010, 5'b00000, 2'b00, 0);
        applyStimulus("clrmem",    7'b0000000, 5'b00100, 5'b00000, 2'b00, 0);
        applyStimulus("clrmem",    7'b0000000, 5'b01000, 5'b01000, 2'b00, 0);
        applyStimulus("clrmem",    7'b1000010, 5'b01000, 5'b00000, 2'b00, 0);
        applyStimulus("clrmem",    7'b0000000, 5'b00001, 5'b10000, 2'b00, 0);
        // Halt while waiting in FETCH
        applyStimulus("fhalt",     7'b0000001, 5'b00001, 5'b10000, 2'b00, 0);
        applyStimulus("fhalt",     7'b0000000, 5'b00001, 5'b00010, 2'b00, 0);
        applyStimulus("fhalt",     7'b0000000, 5'b00001, 5'b10000, 2'b00, 0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
